// File: rtl/usb_line_monitor.sv
// USB D+/D- line monitor: synchronizes the raw lines and tracks bus idle, SE0 glitches, EOP and SE1 events.
// Optional build macro USB_LINE_FILTER_EN adds a two-sample glitch filter ahead of line_state.
module usb_line_monitor #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned EOP_MIN_CYCLES = 3,
    parameter int unsigned IDLE_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Dplus,
    input  logic       Dminus,
    output logic [1:0] line_state,
    output logic       Edge,
    output logic       EOP,
    output logic       eop_done,
    output logic       eop_err,
    output logic       idle,
    output logic       se1_err
);

    localparam int unsigned MAX_CNT = (EOP_MIN_CYCLES > IDLE_CYCLES) ? EOP_MIN_CYCLES : IDLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] EOP_LIM  = CNT_W'(EOP_MIN_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_SE0_CNT,
        ST_EOP
    } state_t;

    logic [1:0]       sync_q [SYNC_STAGES];
    logic [1:0]       sync_d [SYNC_STAGES];
    logic [1:0]       ls;
    logic [1:0]       prev_q, prev_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] se0_cnt_q, se0_cnt_d;
    logic [CNT_W-1:0] j_cnt_q, j_cnt_d;
    logic             edge_q, edge_d;
    logic             eop_q, eop_d;
    logic             eop_done_q, eop_done_d;
    logic             eop_err_q, eop_err_d;
    logic             idle_q, idle_d;
    logic             se1_err_q, se1_err_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_ONE;
    endfunction

    always_comb begin
        sync_d[0] = {Dplus, Dminus};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

`ifdef USB_LINE_FILTER_EN
    // Accept the last stage only when the stage behind it agrees: two identical samples, one extra cycle.
    logic [1:0] ls_q, ls_d;
    always_comb begin
        ls_d = ls_q;
        if (sync_q[SYNC_STAGES-1] == sync_q[SYNC_STAGES-2]) begin
            ls_d = sync_q[SYNC_STAGES-1];
        end
    end
    assign ls = ls_q;
`else
    assign ls = sync_q[SYNC_STAGES-1];
`endif

    // Next-state logic; the J run counter tracks consecutive J samples regardless of state.
    always_comb begin
        state_d    = state_q;
        se0_cnt_d  = se0_cnt_q;
        j_cnt_d    = (ls == LS_J) ? sat_inc(j_cnt_q) : '0;
        eop_done_d = 1'b0;
        eop_err_d  = 1'b0;
        prev_d     = ls;
        edge_d     = (ls != prev_q);
        se1_err_d  = (ls == LS_SE1) && (prev_q != LS_SE1);

        case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (ls == LS_SE0) begin
                    se0_cnt_d = CNT_ONE;
                    state_d   = (CNT_ONE >= EOP_LIM) ? ST_EOP : ST_SE0_CNT;
                end else if (ls != LS_J) begin
                    state_d = ST_ACTIVE;
                end else if (state_q == ST_ACTIVE && j_cnt_d >= IDLE_LIM) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SE0_CNT: begin
                if (ls == LS_SE0) begin
                    se0_cnt_d = sat_inc(se0_cnt_q);
                    if (se0_cnt_d >= EOP_LIM) begin
                        state_d = ST_EOP;
                    end
                end else begin
                    se0_cnt_d = '0;
                    state_d   = ST_ACTIVE;
                end
            end
            ST_EOP: begin
                if (ls != LS_SE0) begin
                    se0_cnt_d = '0;
                    if (ls == LS_J) begin
                        state_d    = ST_IDLE;
                        eop_done_d = 1'b1;
                    end else begin
                        state_d   = ST_ACTIVE;
                        eop_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                se0_cnt_d = '0;
            end
        endcase

        eop_d  = (state_d == ST_EOP);
        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= LS_J;
            end
`ifdef USB_LINE_FILTER_EN
            ls_q       <= LS_J;
`endif
            prev_q     <= LS_J;
            state_q    <= ST_IDLE;
            se0_cnt_q  <= '0;
            j_cnt_q    <= '0;
            edge_q     <= 1'b0;
            eop_q      <= 1'b0;
            eop_done_q <= 1'b0;
            eop_err_q  <= 1'b0;
            idle_q     <= 1'b1;
            se1_err_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
`ifdef USB_LINE_FILTER_EN
            ls_q       <= ls_d;
`endif
            prev_q     <= prev_d;
            state_q    <= state_d;
            se0_cnt_q  <= se0_cnt_d;
            j_cnt_q    <= j_cnt_d;
            edge_q     <= edge_d;
            eop_q      <= eop_d;
            eop_done_q <= eop_done_d;
            eop_err_q  <= eop_err_d;
            idle_q     <= idle_d;
            se1_err_q  <= se1_err_d;
        end
    end

    assign line_state = ls;
    assign Edge       = edge_q;
    assign EOP        = eop_q;
    assign eop_done   = eop_done_q;
    assign eop_err    = eop_err_q;
    assign idle       = idle_q;
    assign se1_err    = se1_err_q;

endmodule

// File: doc/usb_line_monitor.md
USB_LINE_MONITOR -- requirements
Module: usb_line_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of input synchronizer flops per line, legal range 2..4.
REQ-002 Parameter EOP_MIN_CYCLES, default 3: consecutive SE0 samples required to declare EOP, legal range 1..255.
REQ-003 Parameter IDLE_CYCLES, default 8: consecutive J samples required to declare bus idle, legal range 1..255.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 Dplus  input  1  raw USB D+ line, asynchronous to clk.
REQ-007 Dminus  input  1  raw USB D- line, asynchronous to clk.
REQ-008 line_state  output  2  accepted line state {D+,D-}: 00 SE0, 01 K, 10 J, 11 SE1.
REQ-009 Edge  output  1  one-cycle pulse on any change of line_state.
REQ-010 EOP  output  1  level; high while the FSM is in state EOP.
REQ-011 eop_done  output  1  one-cycle pulse on a valid EOP-to-J exit.
REQ-012 eop_err  output  1  one-cycle pulse on an EOP exit to K or SE1.
REQ-013 idle  output  1  level; high while the FSM is in state IDLE.
REQ-014 se1_err  output  1  one-cycle pulse whenever line_state becomes 11.

Function
REQ-015 Each line passes through SYNC_STAGES flops; line_state equals the synchronized pair, so pin-to-line_state latency is SYNC_STAGES cycles.
REQ-016 A register prev_state holds the previous line_state; Edge is registered and pulses in the cycle after line_state differs from prev_state.
REQ-017 FSM states: IDLE, ACTIVE, SE0_CNT, EOP; all outputs are registered.
REQ-018 IDLE: K or SE1 -> ACTIVE; SE0 -> SE0_CNT with count=1; J -> stay.
REQ-019 ACTIVE: SE0 -> SE0_CNT with count=1; J held for IDLE_CYCLES consecutive cycles -> IDLE; any non-J sample clears the J count.
REQ-020 SE0_CNT: SE0 increments count, and count reaching EOP_MIN_CYCLES -> EOP; any non-SE0 sample before that -> ACTIVE with count cleared (a short SE0 is a glitch, not an EOP).
REQ-021 EOP: SE0 -> stay; J -> IDLE with one eop_done pulse; K or SE1 -> ACTIVE with one eop_err pulse.
REQ-022 If EOP_MIN_CYCLES=1, the first SE0 sample enters EOP directly from IDLE or ACTIVE.
REQ-023 Counter width is $clog2(max(EOP_MIN_CYCLES,IDLE_CYCLES)+1); counters saturate and never wrap.
REQ-024 When SE1 and a state transition occur in the same cycle, se1_err and the transition both take effect.

Reset
REQ-025 While rst=1: all synchronizer flops, line_state and prev_state load J (2'b10), the FSM enters IDLE, and counters clear.
REQ-026 While rst=1: Edge, EOP, eop_done, eop_err and se1_err are 0 and idle is 1.
REQ-027 Reset asserted mid-EOP or mid-count aborts the operation with no eop_done or eop_err pulse.

Configuration
REQ-028 Macro USB_LINE_FILTER_EN defined: line_state updates only after two consecutive identical synchronized samples, which adds 1 cycle of latency; single-cycle glitches produce no Edge pulse.
REQ-029 Macro USB_LINE_FILTER_EN undefined: no filter; line_state is the raw synchronized pair, per REQ-015.

Verification (defaults, filter off)
REQ-030 Reset released, bus at J for 20 cycles -> idle=1, EOP=0, no Edge pulses, line_state=10.
REQ-031 J then K at cycle 10 -> line_state=01 at cycle 12, Edge pulse at cycle 13, idle falls.
REQ-032 K, then SE0 for 3 cycles, then J -> EOP rises after the 3rd SE0 sample, exactly one eop_done pulse after J; 8 further J cycles -> idle=1.
REQ-033 K, then SE0 for 2 cycles, then K -> EOP never asserts, FSM returns to ACTIVE, no eop_done.
REQ-034 EOP reached, then K -> one eop_err pulse, EOP=0; separately, D+=D-=1 -> one se1_err pulse.
REQ-035 Filter on, one-cycle K glitch in J -> line_state stays 10 and no Edge pulse; rst mid-EOP -> idle=1, no eop_done pulse.
